rdma_wqe_sched: RTL and testbench
=================================

# rdma_wqe_sched

Round-robin WQE scheduler for the simple_rdma application. It sits between host doorbells and the TX/SQ config RAM read port. It keeps a per-QP count of posted, unissued WQEs and picks the next QP fairly. It then reads that QP's 512-bit WQE descriptor from the config RAM (1-cycle read latency) and presents it on a valid/ready stream to the TX data processor.

## Interface
Parameters:
- CONFIG_RAM_AWIDTH, 4: QP index width; QP_COUNT = 2**CONFIG_RAM_AWIDTH (16).
- CONFIG_RAM_DWIDTH, 512: WQE descriptor width.
- CREDIT_WIDTH, 8: per-QP pending-WQE counter width.

Ports:
- clk  in  1  Single clock; all logic is on its rising edge.
- rst_n  in  1  Reset, asynchronous, active-low.
- sched_en  in  1  High: new QP selections are allowed. Low: an in-flight WQE completes, no new pick.
- db_valid  in  1  Doorbell strobe, one cycle per doorbell; always accepted.
- db_qpn  in  CONFIG_RAM_AWIDTH  QP being rung.
- db_count  in  CREDIT_WIDTH  Number of WQEs posted by this doorbell; 0 is legal and has no effect.
- cfg_ram_ren  out  1  Config RAM read enable.
- cfg_ram_raddr  out  CONFIG_RAM_AWIDTH  Config RAM read address (QP index).
- cfg_ram_rdata  in  CONFIG_RAM_DWIDTH  Read data, valid exactly 1 cycle after cfg_ram_ren.
- m_wqe_valid  out  1  WQE output valid.
- m_wqe_ready  in  1  WQE output ready.
- m_wqe_data  out  CONFIG_RAM_DWIDTH  WQE descriptor.
- m_wqe_qpn  out  CONFIG_RAM_AWIDTH  Source QP of m_wqe_data.
- pending_mask  out  QP_COUNT  Bit q is high when QP q's counter is non-zero (registered).
- db_overflow  out  1  Sticky flag; set when any counter saturates. Cleared only by reset.
- busy  out  1  High when the FSM is not in IDLE.

## Operation
- Counters: cnt[q] holds CREDIT_WIDTH bits. Each cycle, cnt[q]_next = cnt[q] + (db hit q ? db_count : 0) − (issue hit q ? 1 : 0).
  - The sum is computed CREDIT_WIDTH+1 bits wide.
  - If the result exceeds 2**CREDIT_WIDTH−1, cnt[q] clamps to that maximum and db_overflow sets.
  - A doorbell and an issue to the same QP in the same cycle combine into one net update; neither is lost.
- Arbiter: round-robin over pending_mask.
  - Search starts at last_qpn+1 and wraps modulo QP_COUNT.
  - last_qpn resets to QP_COUNT−1, so QP 0 has first priority after reset.
  - last_qpn updates to the granted QP on each grant.
- FSM states: IDLE, RD, CAP, OUT.
  - IDLE: if sched_en and pending_mask≠0, then grant_qpn ← the arbiter winner, the issue decrement is applied to cnt[winner] this cycle, and the FSM goes to RD. Otherwise it stays in IDLE.
  - RD: cfg_ram_ren=1, cfg_ram_raddr=grant_qpn. Go to CAP.
  - CAP: m_wqe_data ← cfg_ram_rdata, m_wqe_qpn ← grant_qpn, m_wqe_valid ← 1. Go to OUT.
  - OUT: hold m_wqe_valid, m_wqe_data and m_wqe_qpn stable until m_wqe_valid & m_wqe_ready. On that handshake, clear m_wqe_valid and go to IDLE.
- cfg_ram_ren is high only in RD. cfg_ram_raddr holds its last value otherwise.
- sched_en is sampled only in IDLE. Deasserting it in RD, CAP or OUT does not abort the WQE.
- pending_mask reflects counters after the cycle's update; it is used by the next IDLE evaluation.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - all cnt = 0; pending_mask = 0; db_overflow = 0
  - FSM in IDLE; busy = 0
  - cfg_ram_ren = 0; cfg_ram_raddr = 0
  - m_wqe_valid = 0; m_wqe_data = 0; m_wqe_qpn = 0
  - last_qpn = QP_COUNT−1
- Reset mid-operation discards any WQE in flight and all counters.
- Latency: doorbell in cycle 0, counter visible in cycle 1, IDLE grant in cycle 1, RD in cycle 2, CAP in cycle 3, m_wqe_valid high in cycle 4.
- Throughput: at most one WQE per 4 cycles (IDLE→RD→CAP→OUT with ready already high).
- Backpressure: m_wqe_ready low holds the FSM in OUT. Doorbells continue to be accepted during OUT.
- No combinational path from any input to any output.

## Test plan
- Single doorbell: qpn=3, count=1, RAM[3]=0xA5…; → m_wqe_valid rises exactly 4 cycles later with qpn=3 and data=RAM[3]. pending_mask[3] is 1 for one cycle, then 0.
- Fairness: doorbells qpn=2 count=2, qpn=5 count=1, qpn=15 count=1, with ready held high → output order 2, 5, 15, 2, then idle. busy deasserts.
- Simultaneous events: while qpn=7 (cnt=1) is granted in IDLE, a doorbell for qpn=7 with count=3 arrives → cnt[7]=3 afterward. Four WQEs for QP 7 are emitted in total.
- Saturation: qpn=0 count=200, then count=100 (CREDIT_WIDTH=8) → cnt[0]=255 and db_overflow=1 and stays 1. Exactly 255 WQEs are emitted.
- Backpressure and enable: ready held low for 10 cycles in OUT → data and qpn stay stable, and cfg_ram_ren stays 0. With sched_en=0 and pending work, no grant occurs. Raising sched_en gives a grant the same cycle.
- Reset mid-flight: assert rst_n=0 during CAP → all outputs return to reset values immediately. After release, the bench sees no WQE until a new doorbell.

Source files
------------

// File: rtl/rdma_wqe_sched.sv
// Round-robin WQE scheduler: per-QP pending-WQE counters, fair QP pick, one-cycle
// config RAM read of the WQE descriptor, then a valid/ready WQE output stream.
module rdma_wqe_sched #(
   parameter int unsigned CONFIG_RAM_AWIDTH = 4,
   parameter int unsigned CONFIG_RAM_DWIDTH = 512,
   parameter int unsigned CREDIT_WIDTH      = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              sched_en,
   input  logic                              db_valid,
   input  logic [CONFIG_RAM_AWIDTH-1:0]      db_qpn,
   input  logic [CREDIT_WIDTH-1:0]           db_count,
   output logic                              cfg_ram_ren,
   output logic [CONFIG_RAM_AWIDTH-1:0]      cfg_ram_raddr,
   input  logic [CONFIG_RAM_DWIDTH-1:0]      cfg_ram_rdata,
   output logic                              m_wqe_valid,
   input  logic                              m_wqe_ready,
   output logic [CONFIG_RAM_DWIDTH-1:0]      m_wqe_data,
   output logic [CONFIG_RAM_AWIDTH-1:0]      m_wqe_qpn,
   output logic [2**CONFIG_RAM_AWIDTH-1:0]   pending_mask,
   output logic                              db_overflow,
   output logic                              busy
);
   localparam int unsigned QpCount = 2 ** CONFIG_RAM_AWIDTH;
   localparam logic [CREDIT_WIDTH:0] SumOne = 1;

   typedef logic [CONFIG_RAM_AWIDTH-1:0] qpn_t;
   typedef logic [CREDIT_WIDTH-1:0]      cnt_t;
   typedef enum logic [1:0] {StIdle, StRd, StCap, StOut} state_e;

   state_e                 state_q, state_d;
   cnt_t                   cnt_q [QpCount];
   cnt_t                   cnt_d [QpCount];
   logic [QpCount-1:0]     pend_q, pend_d;
   logic                   ovf_q, ovf_d;
   qpn_t                   last_q, grant_q, win_qpn;
   logic                   win_found, issue;
   logic                   valid_q;
   logic [CONFIG_RAM_DWIDTH-1:0] data_q;
   qpn_t                   qpn_q;

   // Round-robin search starting just after the last granted QP.
   always_comb begin
      qpn_t idx;
      idx       = '0;
      win_found = 1'b0;
      win_qpn   = '0;
      for (int i = 1; i <= QpCount; i++) begin
         idx = last_q + qpn_t'(i);
         if (!win_found && pend_q[idx]) begin
            win_found = 1'b1;
            win_qpn   = idx;
         end
      end
   end

   assign issue = (state_q == StIdle) && sched_en && win_found;

   // Doorbell add and issue decrement merge into one saturating update per QP.
   always_comb begin
      logic [CREDIT_WIDTH:0] sum;
      sum   = '0;
      ovf_d = ovf_q;
      for (int q = 0; q < QpCount; q++) begin
         sum = {1'b0, cnt_q[q]};
         if (db_valid && (db_qpn == qpn_t'(q))) sum = sum + {1'b0, db_count};
         if (issue && (win_qpn == qpn_t'(q)))   sum = sum - SumOne;
         if (sum[CREDIT_WIDTH]) begin
            cnt_d[q] = '1;
            ovf_d    = 1'b1;
         end else begin
            cnt_d[q] = sum[CREDIT_WIDTH-1:0];
         end
         pend_d[q] = (cnt_d[q] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int q = 0; q < QpCount; q++) cnt_q[q] <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         last_q  <= '1;
         grant_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         if (issue) begin
            last_q  <= win_qpn;
            grant_q <= win_qpn;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         qpn_q   <= '0;
      end else if (state_q == StCap) begin
         valid_q <= 1'b1;
         data_q  <= cfg_ram_rdata;
         qpn_q   <= grant_q;
      end else if ((state_q == StOut) && m_wqe_ready) begin
         valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (issue) state_d = StRd;
         StRd:    state_d = StCap;
         StCap:   state_d = StOut;
         StOut:   if (m_wqe_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cfg_ram_ren = (state_q == StRd);
      busy        = (state_q != StIdle);
   end

   assign cfg_ram_raddr = grant_q;
   assign m_wqe_valid   = valid_q;
   assign m_wqe_data    = data_q;
   assign m_wqe_qpn     = qpn_q;
   assign pending_mask  = pend_q;
   assign db_overflow   = ovf_q;

endmodule

// File: tb/tb_rdma_wqe_sched.sv
// Bench for rdma_wqe_sched: directed scenarios plus random traffic, all checked every
// cycle against a transaction-level model of counters, fair pick and WQE latency.
module tb_rdma_wqe_sched;
   localparam int AW = 4;
   localparam int DW = 512;
   localparam int CW = 8;
   localparam int QN = 16;
   localparam int CMAX = 255;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sched_en = 1'b0;
   logic          db_valid = 1'b0;
   logic [AW-1:0] db_qpn = '0;
   logic [CW-1:0] db_count = '0;
   logic          m_wqe_ready = 1'b0;
   logic          cfg_ram_ren;
   logic [AW-1:0] cfg_ram_raddr;
   logic [DW-1:0] cfg_ram_rdata = '0;
   logic          m_wqe_valid;
   logic [DW-1:0] m_wqe_data;
   logic [AW-1:0] m_wqe_qpn;
   logic [QN-1:0] pending_mask;
   logic          db_overflow;
   logic          busy;

   rdma_wqe_sched #(
      .CONFIG_RAM_AWIDTH(AW),
      .CONFIG_RAM_DWIDTH(DW),
      .CREDIT_WIDTH     (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sched_en     (sched_en),
      .db_valid     (db_valid),
      .db_qpn       (db_qpn),
      .db_count     (db_count),
      .cfg_ram_ren  (cfg_ram_ren),
      .cfg_ram_raddr(cfg_ram_raddr),
      .cfg_ram_rdata(cfg_ram_rdata),
      .m_wqe_valid  (m_wqe_valid),
      .m_wqe_ready  (m_wqe_ready),
      .m_wqe_data   (m_wqe_data),
      .m_wqe_qpn    (m_wqe_qpn),
      .pending_mask (pending_mask),
      .db_overflow  (db_overflow),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Config RAM with one-cycle read latency.
   logic [DW-1:0] ram [QN];
   always @(posedge clk) if (cfg_ram_ren) cfg_ram_rdata <= ram[cfg_ram_raddr];

   // Model: counts per QP, last grant, and the in-flight WQE's age since its grant
   // (1 = RAM read cycle, 2 = capture cycle, 3 = presented on the output).
   int            m_cnt [QN];
   int            m_last;
   bit            m_ovf;
   bit            m_infl;
   int            m_age;
   int            m_g;
   logic [DW-1:0] m_data;
   int            m_qpn;

   int checks = 0;
   int failures = 0;
   int dut_emit [$];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int q = 0; q < QN; q++) m_cnt[q] = 0;
      m_last = QN - 1;
      m_ovf  = 1'b0;
      m_infl = 1'b0;
      m_age  = 0;
      m_g    = 0;
      m_data = '0;
      m_qpn  = 0;
   endtask

   task automatic model_step(input bit en, input bit dv, input int qpn, input int cnt,
                             input bit rdy);
      int w;
      bit iss;
      w   = -1;
      iss = 1'b0;
      if (!m_infl) begin
         if (en) begin
            for (int i = 1; i <= QN; i++) begin
               int k;
               k = (m_last + i) % QN;
               if (w < 0 && m_cnt[k] > 0) w = k;
            end
         end
         if (w >= 0) begin
            iss    = 1'b1;
            m_infl = 1'b1;
            m_age  = 1;
            m_g    = w;
            m_last = w;
         end
      end else if (m_age == 3) begin
         if (rdy) m_infl = 1'b0;
      end else begin
         m_age++;
         if (m_age == 3) begin
            m_data = ram[m_g];
            m_qpn  = m_g;
         end
      end
      for (int q = 0; q < QN; q++) begin
         int c;
         c = m_cnt[q];
         if (dv && qpn == q) c += cnt;
         if (iss && w == q) c -= 1;
         if (c > CMAX) begin
            c     = CMAX;
            m_ovf = 1'b1;
         end
         m_cnt[q] = c;
      end
   endtask

   task automatic compare();
      logic [QN-1:0] pm;
      for (int q = 0; q < QN; q++) pm[q] = (m_cnt[q] != 0);
      chk("m_wqe_valid", DW'(m_wqe_valid), DW'(m_infl && m_age == 3));
      chk("cfg_ram_ren", DW'(cfg_ram_ren), DW'(m_infl && m_age == 1));
      chk("cfg_ram_raddr", DW'(cfg_ram_raddr), DW'(m_g));
      chk("m_wqe_qpn", DW'(m_wqe_qpn), DW'(m_qpn));
      chk("m_wqe_data", m_wqe_data, m_data);
      chk("pending_mask", DW'(pending_mask), DW'(pm));
      chk("db_overflow", DW'(db_overflow), DW'(m_ovf));
      chk("busy", DW'(busy), DW'(m_infl));
   endtask

   // One clock: drive inputs, advance the model, then check at the falling edge.
   task automatic cyc(input bit en, input bit dv, input int qpn, input int cnt, input bit rdy);
      sched_en    = en;
      db_valid    = dv;
      db_qpn      = AW'(qpn);
      db_count    = CW'(cnt);
      m_wqe_ready = rdy;
      if (m_wqe_valid && rdy) dut_emit.push_back(int'(m_wqe_qpn));
      model_step(en, dv, qpn, cnt, rdy);
      @(negedge clk);
      compare();
   endtask

   task automatic drain(input int limit);
      int n;
      bit work;
      n    = 0;
      work = 1'b1;
      while (work && n < limit) begin
         cyc(1'b1, 1'b0, 0, 0, 1'b1);
         n++;
         work = m_infl;
         for (int q = 0; q < QN; q++) if (m_cnt[q] != 0) work = 1'b1;
      end
      if (work) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: still busy after %0d cycles", limit);
      end
   endtask

   function automatic int count_qpn(input int qpn);
      int n;
      n = 0;
      foreach (dut_emit[i]) if (dut_emit[i] == qpn) n++;
      return n;
   endfunction

   initial begin
      int            exp_ord [4];
      int            lat;
      logic [DW-1:0] a5;
      logic [DW-1:0] cap;
      logic [DW-1:0] d0;
      exp_ord = '{2, 5, 15, 2};
      a5      = {64{8'hA5}};
      for (int q = 0; q < QN; q++)
         for (int w = 0; w < DW / 32; w++) ram[q][w*32 +: 32] = $urandom;
      ram[3] = a5;
      model_reset();

      // Reset state.
      repeat (3) @(negedge clk);
      compare();
      rst_n = 1'b1;

      // Fairness: 2 (x2), 5, 15 posted while scheduling is off.
      cyc(1'b0, 1'b1, 2, 2, 1'b1);
      cyc(1'b0, 1'b1, 5, 1, 1'b1);
      cyc(1'b0, 1'b1, 15, 1, 1'b1);
      dut_emit.delete();
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 0, 0, 1'b1);
      chk("fair_count", DW'(dut_emit.size()), DW'(4));
      for (int i = 0; i < 4; i++)
         chk("fair_order", DW'((i < dut_emit.size()) ? dut_emit[i] : -1), DW'(exp_ord[i]));
      chk("fair_busy_end", DW'(busy), DW'(0));

      // Single doorbell: valid exactly 4 cycles after the doorbell cycle.
      dut_emit.delete();
      lat = -1;
      cap = '0;
      cyc(1'b1, 1'b1, 3, 1, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         if (i == 1) chk("single_pend_c1", DW'(pending_mask[3]), DW'(1));
         if (i == 2) chk("single_pend_c2", DW'(pending_mask[3]), DW'(0));
         if (m_wqe_valid && lat < 0) begin
            lat = i;
            cap = m_wqe_data;
            chk("single_qpn", DW'(m_wqe_qpn), DW'(3));
         end
         cyc(1'b1, 1'b0, 0, 0, 1'b1);
      end
      chk("single_latency", DW'(lat), DW'(4));
      chk("single_data", cap, a5);

      // Doorbell and grant to the same QP in the same cycle.
      dut_emit.delete();
      cyc(1'b1, 1'b1, 7, 1, 1'b1);
      cyc(1'b1, 1'b1, 7, 3, 1'b1);
      chk("simul_model_cnt", DW'(m_cnt[7]), DW'(3));
      chk("simul_pend", DW'(pending_mask[7]), DW'(1));
      drain(40);
      chk("simul_emitted", DW'(count_qpn(7)), DW'(4));

      // Saturation on QP 0.
      cyc(1'b0, 1'b1, 0, 200, 1'b1);
      cyc(1'b0, 1'b1, 0, 100, 1'b1);
      chk("sat_model_cnt", DW'(m_cnt[0]), DW'(255));
      chk("sat_ovf", DW'(db_overflow), DW'(1));
      dut_emit.delete();
      drain(1200);
      chk("sat_emitted", DW'(count_qpn(0)), DW'(255));
      chk("sat_ovf_sticky", DW'(db_overflow), DW'(1));

      // Backpressure holds the output stable; doorbells still land meanwhile.
      cyc(1'b1, 1'b1, 9, 1, 1'b0);
      for (int i = 0; i < 10 && !m_wqe_valid; i++) cyc(1'b1, 1'b0, 0, 0, 1'b0);
      chk("bp_valid", DW'(m_wqe_valid), DW'(1));
      d0 = m_wqe_data;
      chk("bp_data_ram", d0, ram[9]);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b0, 0, 0, 1'b0);
         chk("bp_data_hold", m_wqe_data, d0);
         chk("bp_qpn_hold", DW'(m_wqe_qpn), DW'(9));
         chk("bp_ren_low", DW'(cfg_ram_ren), DW'(0));
      end
      cyc(1'b0, 1'b1, 4, 1, 1'b0);
      cyc(1'b0, 1'b0, 0, 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 0, 0, 1'b1);
         chk("en_off_busy", DW'(busy), DW'(0));
         chk("en_off_pend", DW'(pending_mask[4]), DW'(1));
      end
      cyc(1'b1, 1'b0, 0, 0, 1'b1);
      chk("en_on_busy", DW'(busy), DW'(1));
      chk("en_on_ren", DW'(cfg_ram_ren), DW'(1));
      chk("en_on_raddr", DW'(cfg_ram_raddr), DW'(4));
      drain(40);

      // Reset while the WQE is being captured.
      cyc(1'b1, 1'b1, 6, 2, 1'b1);
      cyc(1'b1, 1'b0, 0, 0, 1'b1);
      cyc(1'b1, 1'b0, 0, 0, 1'b1);
      cyc(1'b1, 1'b0, 0, 0, 1'b1);
      chk("pre_rst_busy", DW'(busy), DW'(1));
      rst_n = 1'b0;
      #1;
      chk("rst_valid", DW'(m_wqe_valid), DW'(0));
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_ren", DW'(cfg_ram_ren), DW'(0));
      chk("rst_raddr", DW'(cfg_ram_raddr), DW'(0));
      chk("rst_pend", DW'(pending_mask), DW'(0));
      chk("rst_ovf", DW'(db_overflow), DW'(0));
      chk("rst_data", m_wqe_data, '0);
      chk("rst_qpn", DW'(m_wqe_qpn), DW'(0));
      model_reset();
      @(negedge clk);
      compare();
      rst_n = 1'b1;
      dut_emit.delete();
      for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 0, 0, 1'b1);
      chk("post_rst_emitted", DW'(dut_emit.size()), DW'(0));

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         int c;
         c = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
         cyc($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, $urandom_range(0, QN - 1), c,
             $urandom_range(0, 9) < 7);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
